// File: rtl/berlekamp_massey_solver_pkg.sv
// Shared RS decoder definitions: field width, solver FSM encoding and
// coefficient-index sizing used by the key-equation solver and its bench.
package berlekamp_massey_solver_pkg;

    localparam int GF_WIDTH  = 8;
    localparam int RED_WIDTH = 57;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DISC   = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Bits needed to index coefficients 0..t.
    function automatic int coef_idx_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/berlekamp_massey_solver_if.sv
// Request/result bundle between the syndrome stage, the solver and the
// root-search stage.
interface berlekamp_massey_solver_if
    import berlekamp_massey_solver_pkg::*;
#(
    parameter int MAX_ERRORS = 16
);
    localparam int T = MAX_ERRORS;

    logic                             start;
    logic [GF_WIDTH*2*T-1:0]          syndromes_flat;
    logic [RED_WIDTH-1:0]             reduction_matrix;
    logic                             busy;
    logic                             done;
    logic [GF_WIDTH*(T+1)-1:0]        error_locator_flat;
    logic [coef_idx_width(T):0]       locator_degree;
    logic                             failure;

    modport master (
        output start, syndromes_flat, reduction_matrix,
        input  busy, done, error_locator_flat, locator_degree, failure
    );

    modport slave (
        input  start, syndromes_flat, reduction_matrix,
        output busy, done, error_locator_flat, locator_degree, failure
    );

endinterface

// File: rtl/berlekamp_massey_solver_gf_mult.sv
// GF(2^8) Mastrovito multiplier: carry-less product, high terms folded back
// through the shared reduction rows (row k = x^(8+k) mod p, bit 56 reserved).
module finite_field_multiplier_mastravito
    import berlekamp_massey_solver_pkg::*;
(
    input  logic [GF_WIDTH-1:0]  a,
    input  logic [GF_WIDTH-1:0]  b,
    input  logic [RED_WIDTH-1:0] reduction_matrix,
    output logic [GF_WIDTH-1:0]  product
);

    logic [2*GF_WIDTH-2:0] raw;
    logic                  unused_reserved;

    assign unused_reserved = reduction_matrix[RED_WIDTH-1];

    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < GF_WIDTH; i++) begin
            for (int unsigned j = 0; j < GF_WIDTH; j++) begin
                raw[i+j] = raw[i+j] ^ (a[i] & b[j]);
            end
        end
        product = raw[GF_WIDTH-1:0];
        for (int unsigned k = 0; k < GF_WIDTH - 1; k++) begin
            if (raw[GF_WIDTH+k]) begin
                product = product ^ reduction_matrix[GF_WIDTH*k +: GF_WIDTH];
            end
        end
    end

endmodule

// File: rtl/berlekamp_massey_solver.sv
// Inversionless Berlekamp-Massey key-equation solver: serial discrepancy MAC
// followed by a serial coefficient update, constant latency per solve.
module berlekamp_massey_solver
    import berlekamp_massey_solver_pkg::*;
#(
    parameter int MAX_ERRORS = 16
) (
    input logic                      clk,
    input logic                      rst,
    berlekamp_massey_solver_if.slave bus
);

    localparam int T  = MAX_ERRORS;
    localparam int N  = 2 * T;
    localparam int IW = coef_idx_width(T);
    localparam int RW = $clog2(N);
    localparam int LW = IW + 1;

    logic [1:0]          state;
    logic [GF_WIDTH-1:0] syn    [N];
    logic [GF_WIDTH-1:0] lambda [T+1];
    logic [GF_WIDTH-1:0] b      [T+1];
    logic [GF_WIDTH-1:0] gamma;
    logic [GF_WIDTH-1:0] delta;
    logic [GF_WIDTH-1:0] b_prev;
    logic [IW-1:0]       idx;
    logic [RW-1:0]       r;
    logic [LW-1:0]       l_reg;
    logic                failure_q;
    logic                done_q;

    logic [GF_WIDTH-1:0] lam_sel;
    logic [GF_WIDTH-1:0] syn_sel;
    logic [GF_WIDTH-1:0] b_prev_val;
    logic [GF_WIDTH-1:0] p_disc;
    logic [GF_WIDTH-1:0] p_gl;
    logic [GF_WIDTH-1:0] p_db;
    logic [RW-1:0]       diff;
    logic [LW-1:0]       l_next;
    logic [LW-1:0]       deg;
    logic                swap;

    assign lam_sel    = lambda[idx];
    assign diff       = r - RW'(idx);
    assign syn_sel    = (r >= RW'(idx)) ? syn[diff] : '0;
    assign b_prev_val = (idx == '0) ? '0 : b_prev;
    assign swap       = (delta != '0) && (2 * int'(l_reg) <= int'(r));
    assign l_next     = LW'(int'(r) + 1 - int'(l_reg));

    always_comb begin
        deg = '0;
        for (int unsigned i = 0; i <= T; i++) begin
            if (lambda[i] != '0) deg = LW'(i);
        end
    end

    finite_field_multiplier_mastravito u_mul_disc (
        .a(lam_sel), .b(syn_sel), .reduction_matrix(bus.reduction_matrix), .product(p_disc)
    );
    finite_field_multiplier_mastravito u_mul_gamma (
        .a(gamma), .b(lam_sel), .reduction_matrix(bus.reduction_matrix), .product(p_gl)
    );
    finite_field_multiplier_mastravito u_mul_delta (
        .a(delta), .b(b_prev_val), .reduction_matrix(bus.reduction_matrix), .product(p_db)
    );

    // B is rewritten in place one coefficient per cycle, so the old B_(i-1)
    // is carried forward in b_prev to keep the shift reading pre-update values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gamma     <= '0;
            delta     <= '0;
            b_prev    <= '0;
            idx       <= '0;
            r         <= '0;
            l_reg     <= '0;
            failure_q <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned j = 0; j < N; j++) syn[j] <= '0;
            for (int unsigned i = 0; i <= T; i++) begin
                lambda[i] <= '0;
                b[i]      <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int unsigned j = 0; j < N; j++) begin
                            syn[j] <= bus.syndromes_flat[GF_WIDTH*j +: GF_WIDTH];
                        end
                        for (int unsigned i = 0; i <= T; i++) begin
                            lambda[i] <= (i == 0) ? GF_WIDTH'(1) : '0;
                            b[i]      <= (i == 0) ? GF_WIDTH'(1) : '0;
                        end
                        gamma     <= GF_WIDTH'(1);
                        delta     <= '0;
                        l_reg     <= '0;
                        r         <= '0;
                        idx       <= '0;
                        failure_q <= 1'b0;
                        state     <= DISC;
                    end
                end
                DISC: begin
                    delta <= ((idx == '0) ? '0 : delta) ^ p_disc;
                    if (idx == IW'(T)) begin
                        idx   <= '0;
                        state <= UPDATE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                UPDATE: begin
                    lambda[idx] <= p_gl ^ p_db;
                    b[idx]      <= swap ? lam_sel : b_prev_val;
                    b_prev      <= b[idx];
                    if (idx == IW'(T)) begin
                        idx <= '0;
                        if (swap) begin
                            gamma <= delta;
                            l_reg <= l_next;
                        end
                        if (r == RW'(N - 1)) begin
                            state <= DONE;
                        end else begin
                            r     <= r + 1'b1;
                            state <= DISC;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    failure_q <= (int'(l_reg) > T) || (deg != l_reg);
                    done_q    <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g <= T; g++) begin : g_out
        assign bus.error_locator_flat[GF_WIDTH*g +: GF_WIDTH] = lambda[g];
    end

    assign bus.busy           = (state != IDLE);
    assign bus.done           = done_q;
    assign bus.locator_degree = l_reg;
    assign bus.failure        = failure_q;

endmodule

// File: tb/tb_berlekamp_massey_solver.sv
// Bench for the BM solver: constant-syndrome vector table, hand sequences for
// restart/reset corners, random codewords against a textbook BM model.
module tb_berlekamp_massey_solver;

    typedef logic [7:0] syn_t  [32];
    typedef logic [7:0] coef_t [17];

    typedef struct {
        logic [7:0] s0;
        logic [7:0] rest;
        logic [7:0] exp_l1;
        int         exp_deg;
        logic       exp_fail;
        logic [7:0] exp_raw_l0;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] gf_exp [510];
    int         gf_log [256];
    logic [56:0] rm;

    berlekamp_massey_solver_if #(.MAX_ERRORS(16)) bus16 ();
    berlekamp_massey_solver_if #(.MAX_ERRORS(2))  bus2 ();

    berlekamp_massey_solver #(.MAX_ERRORS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    berlekamp_massey_solver #(.MAX_ERRORS(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gf_exp[gf_log[a] + gf_log[b]];
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        return gf_exp[(255 - gf_log[a]) % 255];
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [135:0] pack(input coef_t c);
        logic [135:0] f;
        f = '0;
        for (int i = 0; i < 17; i++) f[8*i +: 8] = c[i];
        return f;
    endfunction

    // Scale the DUT locator so Lambda_0 = 1; a zero Lambda_0 yields all-ones.
    function automatic logic [135:0] normalise(input logic [135:0] flat, input int t);
        logic [135:0] f;
        logic [7:0]   inv0;
        if (flat[7:0] == 8'h00) return '1;
        inv0 = gf_inv(flat[7:0]);
        f = '0;
        for (int i = 0; i <= t; i++) f[8*i +: 8] = gf_mul(flat[8*i +: 8], inv0);
        return f;
    endfunction

    // Textbook Berlekamp-Massey with inversion, connection polynomial kept to
    // degree t; failure when L exceeds t or the degree disagrees with L.
    task automatic model_bm(input int t, input syn_t s, output coef_t c, output int l, output logic f);
        coef_t      bp, tmp;
        logic [7:0] d, bb, coef;
        int         m, deg;
        for (int i = 0; i < 17; i++) begin
            c[i]  = 8'h00;
            bp[i] = 8'h00;
        end
        c[0] = 8'h01; bp[0] = 8'h01; bb = 8'h01; m = 1; l = 0;
        for (int r = 0; r < 2 * t; r++) begin
            d = 8'h00;
            for (int i = 0; i <= t && i <= r; i++) d ^= gf_mul(c[i], s[r-i]);
            if (d == 8'h00) begin
                m++;
            end else begin
                tmp  = c;
                coef = gf_mul(d, gf_inv(bb));
                for (int i = m; i <= t; i++) c[i] ^= gf_mul(coef, bp[i-m]);
                if (2 * l <= r) begin
                    l = r + 1 - l; bp = tmp; bb = d; m = 1;
                end else begin
                    m++;
                end
            end
        end
        deg = 0;
        for (int i = 0; i <= t; i++) if (c[i] != 8'h00) deg = i;
        f = (l > t) || (deg != l);
    endtask

    // Syndromes S_j = sum e_k * alpha^(p_k*(j+1)); root_poly = prod (1 + X_k x).
    task automatic make_codeword(input int nerr, output syn_t s, output coef_t root_poly);
        int         pos [$];
        logic [7:0] val, xk;
        int         p;
        bit         dup;
        for (int j = 0; j < 32; j++) s[j] = 8'h00;
        for (int i = 0; i < 17; i++) root_poly[i] = 8'h00;
        root_poly[0] = 8'h01;
        while (pos.size() < nerr) begin
            p = int'($urandom_range(0, 254));
            dup = 1'b0;
            foreach (pos[q]) if (pos[q] == p) dup = 1'b1;
            if (!dup) pos.push_back(p);
        end
        foreach (pos[q]) begin
            val = 8'($urandom_range(1, 255));
            for (int j = 0; j < 32; j++) s[j] ^= gf_mul(val, gf_exp[(pos[q] * (j + 1)) % 255]);
            xk = gf_exp[pos[q]];
            for (int i = 16; i >= 1; i--) root_poly[i] ^= gf_mul(xk, root_poly[i-1]);
        end
    endtask

    task automatic drive16(input syn_t s);
        for (int j = 0; j < 32; j++) bus16.syndromes_flat[8*j +: 8] = s[j];
    endtask

    task automatic solve16(input string tag, input syn_t s, input int pulse_a, input int pulse_b);
        int lat;
        drive16(s);
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        check({tag, "_busy"}, 136'(bus16.busy), 136'(1));
        lat = -1;
        for (int c = 1; c <= 1500; c++) begin
            if (c == pulse_a || c == pulse_b) bus16.start = 1'b1;
            @(posedge clk); #1;
            bus16.start = 1'b0;
            if (bus16.done) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, 136'(lat), 136'(1089));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 136'(bus16.done), 136'(0));
    endtask

    task automatic check_vs_model(input string tag, input syn_t s);
        coef_t c;
        int    l;
        logic  f;
        model_bm(16, s, c, l, f);
        check({tag, "_lambda"}, normalise(bus16.error_locator_flat, 16), pack(c));
        check({tag, "_degree"}, 136'(bus16.locator_degree), 136'(l));
        check({tag, "_failure"}, 136'(bus16.failure), 136'(f));
    endtask

    initial begin
        vec_t       vecs [4];
        syn_t       s;
        coef_t      rp;
        logic [7:0] x;
        int         lat2, done_seen, nerr;

        checks = 0;
        errors = 0;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gf_exp[i]       = x;
            gf_exp[i + 255] = x;
            gf_log[x]       = i;
            x = (x[7]) ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        gf_log[0] = 0;
        rm = '0;
        for (int k = 0; k < 7; k++) rm[8*k +: 8] = gf_exp[8 + k];

        vecs[0] = '{s0: 8'h00, rest: 8'h00, exp_l1: 8'h00, exp_deg: 0, exp_fail: 1'b0, exp_raw_l0: 8'h01};
        vecs[1] = '{s0: 8'h01, rest: 8'h01, exp_l1: 8'h01, exp_deg: 1, exp_fail: 1'b0, exp_raw_l0: 8'h01};
        vecs[2] = '{s0: 8'h01, rest: 8'h00, exp_l1: 8'h00, exp_deg: 1, exp_fail: 1'b1, exp_raw_l0: 8'h01};
        vecs[3] = '{s0: 8'h05, rest: 8'h05, exp_l1: 8'h01, exp_deg: 1, exp_fail: 1'b0, exp_raw_l0: 8'h00};

        rst = 1'b1;
        bus16.start = 1'b0; bus16.syndromes_flat = '0; bus16.reduction_matrix = rm;
        bus2.start  = 1'b0; bus2.syndromes_flat  = '0; bus2.reduction_matrix  = rm;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    136'(bus16.busy), 136'(0));
        check("rst_done",    136'(bus16.done), 136'(0));
        check("rst_failure", 136'(bus16.failure), 136'(0));
        check("rst_degree",  136'(bus16.locator_degree), 136'(0));
        check("rst_lambda",  bus16.error_locator_flat, 136'(0));
        check("rst_lambda_t2", 136'(bus2.error_locator_flat), 136'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 32; j++) s[j] = (j == 0) ? vecs[k].s0 : vecs[k].rest;
            solve16($sformatf("vec%0d", k), s, 0, 0);
            check($sformatf("vec%0d_lambda", k), normalise(bus16.error_locator_flat, 16),
                  (136'(vecs[k].exp_l1) << 8) | 136'(1));
            check($sformatf("vec%0d_degree", k), 136'(bus16.locator_degree), 136'(vecs[k].exp_deg));
            check($sformatf("vec%0d_failure", k), 136'(bus16.failure), 136'(vecs[k].exp_fail));
            if (vecs[k].exp_raw_l0 != 8'h00) begin
                check($sformatf("vec%0d_raw_lambda", k), bus16.error_locator_flat,
                      (136'(vecs[k].exp_l1) << 8) | 136'(vecs[k].exp_raw_l0));
            end
        end

        bus2.syndromes_flat = 32'h0000_0001;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (bus2.done) begin
                lat2 = c;
                break;
            end
        end
        check("t2_latency", 136'(lat2), 136'(25));
        check("t2_lambda",  136'(bus2.error_locator_flat), 136'(24'h00_0001));
        check("t2_degree",  136'(bus2.locator_degree), 136'(1));
        check("t2_failure", 136'(bus2.failure), 136'(1));

        make_codeword(4, s, rp);
        solve16("repulse", s, 10, 500);
        check("repulse_lambda", normalise(bus16.error_locator_flat, 16), pack(rp));
        check("repulse_degree", 136'(bus16.locator_degree), 136'(4));
        check("repulse_failure", 136'(bus16.failure), 136'(0));

        make_codeword(6, s, rp);
        drive16(s);
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        for (int c = 1; c < 300; c++) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy",    136'(bus16.busy), 136'(0));
        check("abort_done",    136'(bus16.done), 136'(0));
        check("abort_failure", 136'(bus16.failure), 136'(0));
        check("abort_degree",  136'(bus16.locator_degree), 136'(0));
        check("abort_lambda",  bus16.error_locator_flat, 136'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            if (bus16.done) done_seen++;
        end
        check("abort_no_done", 136'(done_seen), 136'(0));
        make_codeword(9, s, rp);
        solve16("after_abort", s, 0, 0);
        check("after_abort_lambda", normalise(bus16.error_locator_flat, 16), pack(rp));
        check("after_abort_degree", 136'(bus16.locator_degree), 136'(9));
        check("after_abort_failure", 136'(bus16.failure), 136'(0));

        for (int n = 0; n < 16; n++) begin
            if (n == 0)       nerr = 16;
            else if (n == 1)  nerr = 1;
            else if (n < 12)  nerr = int'($urandom_range(1, 16));
            else              nerr = int'($urandom_range(17, 24));
            make_codeword(nerr, s, rp);
            solve16($sformatf("rnd%0d", n), s, 0, 0);
            if (nerr <= 16) begin
                check($sformatf("rnd%0d_lambda", n), normalise(bus16.error_locator_flat, 16), pack(rp));
                check($sformatf("rnd%0d_degree", n), 136'(bus16.locator_degree), 136'(nerr));
                check($sformatf("rnd%0d_failure", n), 136'(bus16.failure), 136'(0));
            end else begin
                check_vs_model($sformatf("rnd%0d", n), s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
